// File: rtl/stream_gen_1d.sv
// Stream source: emits i_num beats of an arithmetic sequence on a valid/ready port.
// Optional STREAM_GEN_THROTTLE_EN inserts i_gap idle cycles after each non-last beat.
module stream_gen_1d #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_soft_reset,
  input  logic                  i_start,
  input  logic [CNT_WIDTH-1:0]  i_num,
  input  logic [DATA_WIDTH-1:0] i_init_dat,
  input  logic [DATA_WIDTH-1:0] i_step,
`ifdef STREAM_GEN_THROTTLE_EN
  input  logic [7:0]            i_gap,
`endif
  output logic [DATA_WIDTH-1:0] o_ot_dat,
  output logic                  o_ot_vld,
  input  logic                  i_ot_rdy,
  output logic                  o_idle,
  output logic                  o_done
);

`ifdef STREAM_GEN_THROTTLE_EN
  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state, state_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  vld_q, vld_d;
`ifdef STREAM_GEN_THROTTLE_EN
  logic [7:0]            gap_q, gap_d;
  logic [7:0]            gcnt_q, gcnt_d;
`endif

  logic xfer;
  logic last;

  assign xfer = vld_q & i_ot_rdy;
  assign last = (cnt_q == (num_q - CNT_ONE));

  always_ff @(posedge clk) begin
    if (reset || i_soft_reset) begin
      state  <= IDLE;
      num_q  <= '0;
      cnt_q  <= '0;
      step_q <= '0;
      dat_q  <= '0;
      vld_q  <= 1'b0;
`ifdef STREAM_GEN_THROTTLE_EN
      gap_q  <= '0;
      gcnt_q <= '0;
`endif
    end else begin
      state  <= state_d;
      num_q  <= num_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      dat_q  <= dat_d;
      vld_q  <= vld_d;
`ifdef STREAM_GEN_THROTTLE_EN
      gap_q  <= gap_d;
      gcnt_q <= gcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (i_start) state_d = (i_num != '0) ? RUN : DONE;
      end
      RUN: begin
        if (xfer) begin
          if (last) state_d = DONE;
`ifdef STREAM_GEN_THROTTLE_EN
          else if (gap_q != '0) state_d = GAP;
`endif
        end
      end
`ifdef STREAM_GEN_THROTTLE_EN
      GAP: begin
        if (gcnt_q <= 8'd1) state_d = RUN;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered datapath; vld/dat only move on a transfer,
  // which keeps them stable under backpressure.
  always_comb begin
    num_d  = num_q;
    cnt_d  = cnt_q;
    step_d = step_q;
    dat_d  = dat_q;
    vld_d  = vld_q;
`ifdef STREAM_GEN_THROTTLE_EN
    gap_d  = gap_q;
    gcnt_d = gcnt_q;
`endif
    case (state)
      IDLE: begin
        if (i_start) begin
          num_d  = i_num;
          step_d = i_step;
          dat_d  = i_init_dat;
          vld_d  = (i_num != '0);
          cnt_d  = '0;
`ifdef STREAM_GEN_THROTTLE_EN
          gap_d  = i_gap;
          gcnt_d = '0;
`endif
        end
      end
      RUN: begin
        if (xfer) begin
          if (last) begin
            vld_d = 1'b0;
          end else begin
            dat_d = dat_q + step_q;
            cnt_d = cnt_q + CNT_ONE;
`ifdef STREAM_GEN_THROTTLE_EN
            if (gap_q != '0) begin
              vld_d  = 1'b0;
              gcnt_d = gap_q;
            end
`endif
          end
        end
      end
`ifdef STREAM_GEN_THROTTLE_EN
      GAP: begin
        if (gcnt_q <= 8'd1) begin
          vld_d  = 1'b1;
          gcnt_d = '0;
        end else begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    o_idle   = (state == IDLE);
    o_done   = (state == DONE);
    o_ot_vld = vld_q;
    o_ot_dat = dat_q;
  end

endmodule

// File: tb/tb_stream_gen_1d.sv
// Self-checking bench for stream_gen_1d: beat scoreboard from the sequence formula,
// directed cycle-exact cases plus randomized commands and ready patterns.
module tb_stream_gen_1d;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, i_soft_reset, i_start, i_ot_rdy;
  logic [CW-1:0] i_num;
  logic [DW-1:0] i_init_dat, i_step, o_ot_dat;
  logic          o_ot_vld, o_idle, o_done;
`ifdef STREAM_GEN_THROTTLE_EN
  logic [7:0]    i_gap;
  int            gap_cmd = 0;
`endif

  always #5 clk = ~clk;

  stream_gen_1d #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .i_soft_reset(i_soft_reset), .i_start(i_start),
    .i_num(i_num), .i_init_dat(i_init_dat), .i_step(i_step),
`ifdef STREAM_GEN_THROTTLE_EN
    .i_gap(i_gap),
`endif
    .o_ot_dat(o_ot_dat), .o_ot_vld(o_ot_vld), .i_ot_rdy(i_ot_rdy),
    .o_idle(o_idle), .o_done(o_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  logic [DW-1:0] exp_q[$];
  bit            chk_en = 1'b0;
  int            last_cyc = -10;
  int            n_done = 0;
  int            n_xfer = 0;
  logic          p_vld = 1'b0, p_rdy = 1'b0;
  logic [DW-1:0] p_dat = '0;

  // Every-cycle compare: beats in order, stability under stall, done timing.
  always @(negedge clk) begin
    if (chk_en) begin
      if (p_vld && !p_rdy) begin
        chk("hold_vld", o_ot_vld, 1);
        chk("hold_dat", o_ot_dat, p_dat);
      end
      if (o_ot_vld && i_ot_rdy) begin
        n_xfer++;
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("beat_dat", o_ot_dat, exp_q.pop_front());
          if (exp_q.size() == 0) last_cyc = cyc_n;
        end
      end
      if (o_done) begin
        n_done++;
        chk("done_timing", cyc_n, last_cyc + 1);
      end
      if (cyc_n == last_cyc + 1) chk("vld_after_last", o_ot_vld, 0);
      chk("idle_vld_excl", o_idle && o_ot_vld, 0);
      p_vld = o_ot_vld;
      p_rdy = i_ot_rdy;
      p_dat = o_ot_dat;
    end else begin
      p_vld = 1'b0;
    end
  end

  int rdy_mode = 0;
  int held = 0;
  int t_start = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy();
    case (rdy_mode)
      0: i_ot_rdy = 1'b1;
      1: i_ot_rdy = ($urandom_range(0, 3) != 0);
      default: begin
        if (o_ot_vld) begin
          if (held < 2) begin i_ot_rdy = 1'b0; held++; end
          else begin i_ot_rdy = 1'b1; held = 0; end
        end else begin
          i_ot_rdy = 1'b0;
        end
      end
    endcase
  endtask

  task automatic start_cmd(input int num, input logic [DW-1:0] init, input logic [DW-1:0] step);
    for (int k = 0; k < num; k++) exp_q.push_back(DW'(int'(init) + k * int'(step)));
    i_start    = 1'b1;
    i_num      = CW'(num);
    i_init_dat = init;
    i_step     = step;
`ifdef STREAM_GEN_THROTTLE_EN
    i_gap      = 8'(gap_cmd);
`endif
    t_start  = cyc_n;
    last_cyc = (num == 0) ? cyc_n : -10;
    cyc();
    i_start    = 1'b0;
    i_num      = CW'($urandom);
    i_init_dat = DW'($urandom);
    i_step     = DW'($urandom);
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      set_rdy();
      @(negedge clk);
      if (o_done) begin
        dcyc = cyc_n;
        break;
      end
      cyc();
    end
    chk("done_seen", dcyc >= 0, 1);
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d, nd0, nx0;
    logic [DW-1:0] basic_v[4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [DW-1:0] wrap_v[3]  = '{8'hFE, 8'hFF, 8'h00};
    reset = 1'b1; i_soft_reset = 1'b0; i_start = 1'b0; i_ot_rdy = 1'b0;
    i_num = '0; i_init_dat = '0; i_step = '0;
`ifdef STREAM_GEN_THROTTLE_EN
    i_gap = '0;
`endif
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_vld", o_ot_vld, 0);
    chk("rst_dat", o_ot_dat, 0);
    chk("rst_done", o_done, 0);
    chk("rst_idle", o_idle, 1);
    cyc();
    chk_en = 1'b1;

    // Basic run, continuous ready
    rdy_mode = 0;
    start_cmd(4, 8'h10, 8'h01);
    for (int k = 0; k < 4; k++) begin
      set_rdy();
      @(negedge clk);
      chk("basic_vld", o_ot_vld, 1);
      chk("basic_dat", o_ot_dat, basic_v[k]);
      chk("basic_idle_low", o_idle, 0);
      cyc();
    end
    @(negedge clk);
    chk("basic_vld_end", o_ot_vld, 0);
    chk("basic_done", o_done, 1);
    cyc();
    @(negedge clk);
    chk("basic_idle", o_idle, 1);
    chk("basic_done_once", o_done, 0);
    cyc();

    // Backpressure: ready low for two cycles on every beat
    rdy_mode = 2; held = 0; nd0 = n_done; nx0 = n_xfer;
    start_cmd(3, 8'hA0, 8'h10);
    wait_done(60, d);
    chk("bp_xfers", n_xfer - nx0, 3);
    chk("bp_dones", n_done - nd0, 1);
    chk("bp_done_cycle", d - t_start, 10);

    // Wrap-around
    rdy_mode = 0;
    start_cmd(3, 8'hFE, 8'h01);
    for (int k = 0; k < 3; k++) begin
      set_rdy();
      @(negedge clk);
      chk("wrap_dat", o_ot_dat, wrap_v[k]);
      cyc();
    end
    wait_done(5, d);
    chk("wrap_done_cycle", d - t_start, 4);

    // Zero length
    start_cmd(0, 8'h55, 8'h03);
    @(negedge clk);
    chk("zero_vld", o_ot_vld, 0);
    chk("zero_done", o_done, 1);
    cyc();
    @(negedge clk);
    chk("zero_idle", o_idle, 1);
    cyc();

    // Start during RUN is ignored
    start_cmd(8, 8'h30, 8'h05);
    set_rdy(); cyc();
    i_start = 1'b1; i_num = CW'(2); i_init_dat = 8'hEE; i_step = 8'h77;
    for (int k = 0; k < 3; k++) begin set_rdy(); cyc(); end
    i_start = 1'b0;
    wait_done(40, d);
    chk("ign_done_cycle", d - t_start, 9);
    @(negedge clk);
    chk("ign_idle_after", o_idle, 1);
    chk("ign_no_rerun", o_ot_vld, 0);
    cyc();

    // Soft reset abort after two beats, coinciding with a start
    nd0 = n_done;
    start_cmd(8, 8'h40, 8'h02);
    set_rdy(); cyc();
    set_rdy(); cyc();
    chk_en = 1'b0;
    i_soft_reset = 1'b1; i_start = 1'b1; i_num = CW'(5);
    cyc();
    i_soft_reset = 1'b0; i_start = 1'b0;
    @(negedge clk);
    chk("abort_vld", o_ot_vld, 0);
    chk("abort_dat", o_ot_dat, 0);
    chk("abort_done", o_done, 0);
    chk("abort_idle", o_idle, 1);
    cyc();
    @(negedge clk);
    chk("abort_no_done", o_done, 0);
    chk("abort_still_idle", o_idle, 1);
    exp_q.delete();
    chk_en = 1'b1;
    cyc();

    // Reset wins over start
    start_cmd(5, 8'h01, 8'h01);
    set_rdy(); cyc();
    chk_en = 1'b0;
    reset = 1'b1; i_start = 1'b1; i_num = CW'(6); i_ot_rdy = 1'b1;
    cyc();
    reset = 1'b0; i_start = 1'b0;
    @(negedge clk);
    chk("rprio_vld", o_ot_vld, 0);
    chk("rprio_dat", o_ot_dat, 0);
    chk("rprio_done", o_done, 0);
    chk("rprio_idle", o_idle, 1);
    cyc();
    @(negedge clk);
    chk("rprio_still_idle", o_idle, 1);
    exp_q.delete();
    chk_en = 1'b1;
    cyc();

`ifdef STREAM_GEN_THROTTLE_EN
    begin
      logic [7:0] pat = 8'b1001_0010;
      rdy_mode = 0; gap_cmd = 2;
      start_cmd(3, 8'h20, 8'h04);
      for (int k = 0; k < 8; k++) begin
        set_rdy();
        @(negedge clk);
        chk("gap_vld", o_ot_vld, pat[7-k]);
        if (k == 7) chk("gap_done", o_done, 1);
        cyc();
      end
      gap_cmd = 0;
    end
`endif

    // Randomized commands with random ready
    rdy_mode = 1;
    for (int r = 0; r < 30; r++) begin
      int n;
      n = (r == 0) ? 1 : $urandom_range(0, 12);
`ifdef STREAM_GEN_THROTTLE_EN
      gap_cmd = $urandom_range(0, 3);
`endif
      nd0 = n_done; nx0 = n_xfer;
      start_cmd(n, DW'($urandom), DW'($urandom));
      wait_done(400, d);
      chk("rand_xfers", n_xfer - nx0, n);
      chk("rand_dones", n_done - nd0, 1);
      chk("rand_queue_empty", exp_q.size(), 0);
      repeat ($urandom_range(0, 2)) cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
